ddr_req_arbiter: RTL and testbench
==================================

Name: ddr_req_arbiter

Overview:
- Shares the single DDR burst port between four requesters: ISA cache read, DATA cache read, jump-address read, and DATA cache store.
- Sits between the caches and the DDR burst controller, after the init/preload writes have finished (ddr_rdy high).
- Grants exactly one burst at a time and holds it until the matching finish.
- Steers read-valid and write-data-request back to the owner and pulses a per-requester done.

Parameters:
- DDR_ADDR_WIDTH, 28, burst address width
- LEN_WIDTH, 10, burst length width
- NUM_REQ, 4, requester count (fixed; index 0 ISA_RD, 1 DATA_RD, 2 JMP_RD, 3 STORE)

Ports:
- mem_clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ddr_rdy  in  1  arbitration enabled only when high
- req  in  NUM_REQ  per-requester request level; held until done
- req_addr  in  NUM_REQ*DDR_ADDR_WIDTH  packed start addresses, slot i at [i*W +: W]
- req_len  in  NUM_REQ*LEN_WIDTH  packed burst lengths
- gnt  out  NUM_REQ  one-hot owner, level for the whole burst
- done  out  NUM_REQ  one-cycle completion pulse to owner
- rd_valid  out  NUM_REQ  rd_burst_data_valid gated to owner (reads only)
- wr_data_req  out  1  wr_burst_data_req gated to STORE owner
- busy  out  1  high when not IDLE
- rd_burst_req, wr_burst_req  out  1 each  to DDR controller
- rd_burst_addr, wr_burst_addr  out  DDR_ADDR_WIDTH  to DDR controller
- rd_burst_len, wr_burst_len  out  LEN_WIDTH  to DDR controller
- rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish  in  1 each  from DDR controller

Behaviour:
- Reset: state IDLE.
  - All outputs 0, including addr/len, gnt, done, busy and both burst reqs.
  - Reset mid-burst drops the burst request immediately; no done pulse is issued.
- States: IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
- IDLE:
  - If ddr_rdy and any req bit is set, select a winner, register its index, address and length, and go to ISSUE.
  - Otherwise stay in IDLE.
- Fixed priority (default): STORE > DATA_RD > JMP_RD > ISA_RD. Stores go first so reads never see stale data.
- ISSUE (cycle N+1 after sampling):
  - gnt[winner]=1.
  - Reads: rd_burst_req=1 with rd_burst_addr and rd_burst_len. STORE: wr_burst_req=1 with wr_burst_addr and wr_burst_len.
  - Go to BUSY.
  - If len==0: issue no DDR request, go straight to DONE.
- BUSY:
  - The burst request level is held, and gnt is held.
  - rd_valid[winner] = rd_burst_data_valid; this path is combinational.
  - wr_data_req = wr_burst_data_req only when the winner is STORE.
  - A finish of the matching direction moves to DONE and deasserts the burst request on the same edge.
  - A finish of the other direction is ignored. If both finishes arrive together, only the matching one counts.
- DONE:
  - done[winner] pulses for exactly one cycle, gnt clears, return to IDLE.
  - Earliest new issue is two cycles after the finish.
- req deasserted mid-burst: the burst cannot be aborted, so it completes normally and done still pulses.
- req changing addr/len mid-burst: no effect; values are latched at arbitration.
- ddr_rdy falling mid-burst: the burst still completes; no new grant is made while it is low.
- Only one of rd_burst_req / wr_burst_req is ever high.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A 2-bit pointer advances to last_winner+1 at DONE, and the search starts at the pointer and wraps 3->0. Pointer resets to 0 (ISA_RD).
- Undefined: fixed priority as above; no pointer register is synthesized.

Decomposition:
- Shared package holds:
  - requester index constants REQ_ISA_RD=0, REQ_DATA_RD=1, REQ_JMP_RD=2, REQ_STORE=3;
  - FSM state encodings ARB_IDLE/ARB_ISSUE/ARB_BUSY/ARB_DONE;
  - the function is_write(idx).
- One natural sub-module, ddr_arb_pick: combinational winner select from req plus pointer, outputting one-hot and index. It is shared by the fixed-priority and round-robin builds.

Test Plan:
- ISA_RD only, addr 0x0008000, len 64: rd_burst_req rises 1 cycle after sampling with addr/len matching; rd_valid[0] follows data_valid; done[0] pulses 1 cycle after rd_burst_finish.
- DATA_RD and STORE requested together, fixed priority: STORE wins with wr_burst_addr=0x0070000, len 17. DATA_RD is granted 2 cycles after wr_burst_finish. wr_data_req is never high during the read.
- ddr_rdy=0 with all reqs high: no burst request and busy stays 0. Raising ddr_rdy gives STORE the grant.
- len=0 on JMP_RD: no DDR request, done[2] pulses within 3 cycles, gnt[2] lasts 1 cycle.
- rst asserted in BUSY during a store: all outputs 0 next cycle, no done pulse. A spurious wr_burst_finish afterwards is ignored.
- ARB_ROUND_ROBIN_EN with all four reqs held: grant order 0,1,2,3,0 with each done pulse unique. wr_burst_finish injected during a read does not end the burst.

Source files
------------

// File: rtl/ddr_req_arbiter_pkg.sv
// Shared definitions for the DDR burst-port arbiter: requester indices, FSM states and helpers.
package ddr_req_arbiter_pkg;

    localparam int ARB_NUM_REQ = 4;

    localparam logic [1:0] REQ_ISA_RD  = 2'd0;
    localparam logic [1:0] REQ_DATA_RD = 2'd1;
    localparam logic [1:0] REQ_JMP_RD  = 2'd2;
    localparam logic [1:0] REQ_STORE   = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_BUSY  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    function automatic logic is_write(input logic [1:0] idx);
        return idx == REQ_STORE;
    endfunction

endpackage

// File: rtl/ddr_arb_pick.sv
// Combinational winner select. The search visits ptr+base(k) for k=0..3, where base is either
// the fixed priority order (STORE, DATA_RD, JMP_RD, ISA_RD) or a plain rotation for round-robin.
module ddr_arb_pick
    import ddr_req_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic [ARB_NUM_REQ-1:0] req,
    input  logic [1:0]             ptr,
    output logic [ARB_NUM_REQ-1:0] onehot,
    output logic [1:0]             idx,
    output logic                   any
);

    function automatic logic [1:0] search_base(input int k);
        if (ROUND_ROBIN) return 2'(k);
        case (k)
            0:       return REQ_STORE;
            1:       return REQ_DATA_RD;
            2:       return REQ_JMP_RD;
            default: return REQ_ISA_RD;
        endcase
    endfunction

    logic [1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 0; k < ARB_NUM_REQ; k++) begin
            cand = ptr + search_base(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Four-way arbiter for the single DDR burst port; one burst granted at a time until its finish.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (STORE first).
module ddr_req_arbiter
    import ddr_req_arbiter_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 10,
    parameter int NUM_REQ        = 4
) (
    input  logic                               mem_clk,
    input  logic                               rst,
    input  logic                               ddr_rdy,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]       req_len,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_REQ-1:0]                 done,
    output logic [NUM_REQ-1:0]                 rd_valid,
    output logic                               wr_data_req,
    output logic                               busy,
    output logic                               rd_burst_req,
    output logic                               wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr,
    output logic [LEN_WIDTH-1:0]               rd_burst_len,
    output logic [LEN_WIDTH-1:0]               wr_burst_len,
    input  logic                               rd_burst_data_valid,
    input  logic                               wr_burst_data_req,
    input  logic                               rd_burst_finish,
    input  logic                               wr_burst_finish
);

    arb_state_t                state, state_nxt;
    logic [1:0]                win_idx;
    logic [NUM_REQ-1:0]        win_onehot;
    logic [DDR_ADDR_WIDTH-1:0] win_addr;
    logic [LEN_WIDTH-1:0]      win_len;

    logic [NUM_REQ-1:0]        pick_onehot;
    logic [1:0]                pick_idx;
    logic                      pick_any;
    logic                      arb_take;
    logic                      win_wr;
    logic                      burst_on;
    logic [1:0]                ptr;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;

    always_ff @(posedge mem_clk) begin
        if (rst)                    ptr <= '0;
        else if (state == ARB_DONE) ptr <= win_idx + 2'd1;
    end
`else
    localparam bit RR = 1'b0;

    assign ptr = '0;
`endif

    ddr_arb_pick #(.ROUND_ROBIN(RR)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign arb_take = (state == ARB_IDLE) && ddr_rdy && pick_any;
    assign win_wr   = is_write(win_idx);

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            win_idx    <= '0;
            win_onehot <= '0;
        end else begin
            state <= state_nxt;
            if (arb_take) begin
                win_idx    <= pick_idx;
                win_onehot <= pick_onehot;
            end
        end
    end

    // Address/length are burst payload; outputs are gated by the burst request so they read 0 when idle.
    always_ff @(posedge mem_clk) begin
        if (arb_take) begin
            win_addr <= req_addr[int'(pick_idx)*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
            win_len  <= req_len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (arb_take) state_nxt = ARB_ISSUE;
            ARB_ISSUE: state_nxt = (win_len == '0) ? ARB_DONE : ARB_BUSY;
            ARB_BUSY:  if (win_wr ? wr_burst_finish : rd_burst_finish) state_nxt = ARB_DONE;
            ARB_DONE:  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // A zero-length grant never reaches the DDR controller.
    assign burst_on = ((state == ARB_ISSUE) || (state == ARB_BUSY)) && (win_len != '0);

    assign rd_burst_req  = burst_on && !win_wr;
    assign wr_burst_req  = burst_on && win_wr;
    assign rd_burst_addr = rd_burst_req ? win_addr : '0;
    assign rd_burst_len  = rd_burst_req ? win_len  : '0;
    assign wr_burst_addr = wr_burst_req ? win_addr : '0;
    assign wr_burst_len  = wr_burst_req ? win_len  : '0;

    assign gnt  = ((state == ARB_ISSUE) || (state == ARB_BUSY)) ? win_onehot : '0;
    assign done = (state == ARB_DONE) ? win_onehot : '0;
    assign busy = (state != ARB_IDLE);

    assign rd_valid    = (state == ARB_BUSY && !win_wr && rd_burst_data_valid) ? win_onehot : '0;
    assign wr_data_req = (state == ARB_BUSY) && win_wr && wr_burst_data_req;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Scoreboard bench for ddr_req_arbiter: expected grants queued at stimulus, popped when issued.
module tb_ddr_req_arbiter;

    localparam int AW = 28;
    localparam int LW = 10;
    localparam int NR = 4;

    logic              mem_clk = 1'b0;
    logic              rst;
    logic              ddr_rdy;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     gnt, done, rd_valid;
    logic              wr_data_req, busy, rd_burst_req, wr_burst_req;
    logic [AW-1:0]     rd_burst_addr, wr_burst_addr;
    logic [LW-1:0]     rd_burst_len, wr_burst_len;
    logic              rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish;

    ddr_req_arbiter #(.DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .NUM_REQ(NR)) dut (
        .mem_clk(mem_clk), .rst(rst), .ddr_rdy(ddr_rdy), .req(req),
        .req_addr(req_addr), .req_len(req_len), .gnt(gnt), .done(done),
        .rd_valid(rd_valid), .wr_data_req(wr_data_req), .busy(busy),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        logic [1:0]    idx;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
    endtask

    task automatic expect_grant(input int i);
        exp_t e;
        e.idx  = 2'(i);
        e.addr = req_addr[i*AW +: AW];
        e.len  = req_len[i*LW +: LW];
        sb.push_back(e);
    endtask

    // An empty queue yields an X address so the caller's comparison fails.
    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            e.idx = 2'd0; e.addr = 'x; e.len = 'x;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ddr_rdy = 1'b0; req = '0; req_addr = '0; req_len = '0;
        rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0;
        rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
        tick(); tick();
        vectors++; if ({gnt, done, rd_valid, busy, rd_burst_req, wr_burst_req, wr_data_req} !== '0) begin
            miscompares++; $display("FAIL reset_ctrl got=%b exp=0", {gnt, done, rd_valid, busy, rd_burst_req, wr_burst_req, wr_data_req}); end
        vectors++; if ({rd_burst_addr, wr_burst_addr, rd_burst_len, wr_burst_len} !== '0) begin
            miscompares++; $display("FAIL reset_addr_len got=%h exp=0", {rd_burst_addr, wr_burst_addr, rd_burst_len, wr_burst_len}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_isa_read();
        exp_t e;
        set_slot(0, 28'h0008000, 10'd64); ddr_rdy = 1'b1; req = 4'b0001; expect_grant(0);
        tick();
        pop_exp(e);
        vectors++; if (gnt !== (4'b1 << e.idx)) begin miscompares++; $display("FAIL isa_gnt got=%b exp=%b", gnt, 4'b1 << e.idx); end
        vectors++; if ({rd_burst_req, wr_burst_req, busy} !== 3'b101) begin miscompares++; $display("FAIL isa_req got=%b exp=101", {rd_burst_req, wr_burst_req, busy}); end
        vectors++; if (rd_burst_addr !== e.addr) begin miscompares++; $display("FAIL isa_addr got=%h exp=%h", rd_burst_addr, e.addr); end
        vectors++; if (rd_burst_len !== e.len) begin miscompares++; $display("FAIL isa_len got=%0d exp=%0d", rd_burst_len, e.len); end
        tick();
        rd_burst_data_valid = 1'b1; wr_burst_data_req = 1'b1; #1;
        vectors++; if (rd_valid !== 4'b0001) begin miscompares++; $display("FAIL isa_rd_valid got=%b exp=0001", rd_valid); end
        vectors++; if (wr_data_req !== 1'b0) begin miscompares++; $display("FAIL isa_wr_data_req got=%b exp=0", wr_data_req); end
        rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0; #1;
        vectors++; if (rd_valid !== 4'b0000) begin miscompares++; $display("FAIL isa_rd_valid_low got=%b exp=0000", rd_valid); end
        ddr_rdy = 1'b0; req = 4'b0000; set_slot(0, 28'h0ABCDE0, 10'd3);
        tick();
        vectors++; if ({gnt, rd_burst_req} !== 5'b00011) begin miscompares++; $display("FAIL isa_hold got=%b exp=00011", {gnt, rd_burst_req}); end
        vectors++; if (rd_burst_addr !== 28'h0008000) begin miscompares++; $display("FAIL isa_addr_latched got=%h exp=0008000", rd_burst_addr); end
        rd_burst_finish = 1'b1;
        tick();
        rd_burst_finish = 1'b0;
        vectors++; if ({done, gnt, rd_burst_req} !== 9'b0001_0000_0) begin miscompares++; $display("FAIL isa_done got=%b exp=000100000", {done, gnt, rd_burst_req}); end
        tick();
        vectors++; if ({done, busy} !== 5'b0) begin miscompares++; $display("FAIL isa_idle got=%b exp=00000", {done, busy}); end
        ddr_rdy = 1'b1;
    endtask

    task automatic test_store_priority();
        exp_t e;
        set_slot(1, 28'h0123400, 10'd8); set_slot(3, 28'h0070000, 10'd17);
        req = 4'b1010; expect_grant(3); expect_grant(1);
        tick();
        pop_exp(e);
        vectors++; if (gnt !== (4'b1 << e.idx)) begin miscompares++; $display("FAIL st_gnt got=%b exp=%b", gnt, 4'b1 << e.idx); end
        vectors++; if ({wr_burst_req, rd_burst_req} !== 2'b10) begin miscompares++; $display("FAIL st_req got=%b exp=10", {wr_burst_req, rd_burst_req}); end
        vectors++; if ({wr_burst_addr, wr_burst_len} !== {e.addr, e.len}) begin miscompares++; $display("FAIL st_addr_len got=%h/%0d exp=%h/%0d", wr_burst_addr, wr_burst_len, e.addr, e.len); end
        tick();
        wr_burst_data_req = 1'b1; rd_burst_data_valid = 1'b1; #1;
        vectors++; if ({wr_data_req, rd_valid} !== 5'b1_0000) begin miscompares++; $display("FAIL st_steer got=%b exp=10000", {wr_data_req, rd_valid}); end
        wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b1;
        tick();
        rd_burst_finish = 1'b0;
        vectors++; if ({gnt, wr_burst_req} !== 5'b1000_1) begin miscompares++; $display("FAIL st_rd_finish_ignored got=%b exp=10001", {gnt, wr_burst_req}); end
        wr_burst_finish = 1'b1; rd_burst_finish = 1'b1;
        tick();
        wr_burst_finish = 1'b0; rd_burst_finish = 1'b0; req = 4'b0010;
        vectors++; if ({done, wr_burst_req} !== 5'b1000_0) begin miscompares++; $display("FAIL st_done got=%b exp=10000", {done, wr_burst_req}); end
        tick();
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL st_gap got=%b exp=0000", gnt); end
        tick();
        pop_exp(e);
        vectors++; if (gnt !== (4'b1 << e.idx)) begin miscompares++; $display("FAIL dr_gnt got=%b exp=%b", gnt, 4'b1 << e.idx); end
        vectors++; if ({rd_burst_req, wr_burst_req, rd_burst_addr, rd_burst_len} !== {2'b10, e.addr, e.len}) begin
            miscompares++; $display("FAIL dr_req got=%b%b %h/%0d exp=10 %h/%0d", rd_burst_req, wr_burst_req, rd_burst_addr, rd_burst_len, e.addr, e.len); end
        tick();
        wr_burst_data_req = 1'b1; #1;
        vectors++; if (wr_data_req !== 1'b0) begin miscompares++; $display("FAIL dr_wr_data_req got=%b exp=0", wr_data_req); end
        wr_burst_data_req = 1'b0; rd_burst_finish = 1'b1;
        tick();
        rd_burst_finish = 1'b0; req = 4'b0000;
        vectors++; if (done !== 4'b0010) begin miscompares++; $display("FAIL dr_done got=%b exp=0010", done); end
        tick();
    endtask

    task automatic test_rdy_gate();
        exp_t e;
        set_slot(0, 28'h0008000, 10'd64); set_slot(1, 28'h0123400, 10'd8);
        set_slot(2, 28'h0200000, 10'd5);  set_slot(3, 28'h0070000, 10'd17);
        ddr_rdy = 1'b0; req = 4'b1111;
        repeat (3) begin
            tick();
            vectors++; if ({busy, rd_burst_req, wr_burst_req} !== 3'b000) begin miscompares++; $display("FAIL rdy_low got=%b exp=000", {busy, rd_burst_req, wr_burst_req}); end
        end
        expect_grant(3); ddr_rdy = 1'b1;
        tick();
        pop_exp(e);
        vectors++; if ({gnt, wr_burst_req, wr_burst_addr} !== {4'b1 << e.idx, 1'b1, e.addr}) begin
            miscompares++; $display("FAIL rdy_rise got=%b %b %h exp=%b 1 %h", gnt, wr_burst_req, wr_burst_addr, 4'b1 << e.idx, e.addr); end
        tick();
        wr_burst_finish = 1'b1;
        tick();
        wr_burst_finish = 1'b0; req = 4'b0000;
        vectors++; if (done !== 4'b1000) begin miscompares++; $display("FAIL rdy_done got=%b exp=1000", done); end
        tick();
    endtask

    task automatic test_zero_len();
        exp_t e;
        set_slot(2, 28'h0200000, 10'd0); ddr_rdy = 1'b1; req = 4'b0100; expect_grant(2);
        tick();
        pop_exp(e);
        vectors++; if ({gnt, rd_burst_req, wr_burst_req} !== {4'b1 << e.idx, 2'b00}) begin
            miscompares++; $display("FAIL zl_issue got=%b exp=%b00", {gnt, rd_burst_req, wr_burst_req}, 4'b1 << e.idx); end
        req = 4'b0000;
        tick();
        vectors++; if ({done, gnt, rd_burst_req, wr_burst_req} !== 10'b0100_0000_00) begin
            miscompares++; $display("FAIL zl_done got=%b exp=0100000000", {done, gnt, rd_burst_req, wr_burst_req}); end
        tick();
        vectors++; if ({done, busy} !== 5'b0) begin miscompares++; $display("FAIL zl_idle got=%b exp=00000", {done, busy}); end
    endtask

    task automatic test_reset_mid_store();
        exp_t e;
        set_slot(3, 28'h0070000, 10'd5); ddr_rdy = 1'b1; req = 4'b1000; expect_grant(3);
        tick();
        pop_exp(e);
        vectors++; if ({gnt, wr_burst_req} !== {4'b1 << e.idx, 1'b1}) begin miscompares++; $display("FAIL rm_issue got=%b exp=%b1", {gnt, wr_burst_req}, 4'b1 << e.idx); end
        tick();
        rst = 1'b1; req = 4'b0000;
        tick();
        vectors++; if ({gnt, done, rd_valid, busy, rd_burst_req, wr_burst_req, wr_data_req} !== '0) begin
            miscompares++; $display("FAIL rm_ctrl got=%b exp=0", {gnt, done, rd_valid, busy, rd_burst_req, wr_burst_req, wr_data_req}); end
        vectors++; if ({wr_burst_addr, wr_burst_len} !== '0) begin miscompares++; $display("FAIL rm_addr got=%h exp=0", {wr_burst_addr, wr_burst_len}); end
        rst = 1'b0; wr_burst_finish = 1'b1;
        tick();
        wr_burst_finish = 1'b0;
        vectors++; if ({done, busy} !== 5'b0) begin miscompares++; $display("FAIL rm_spurious got=%b exp=00000", {done, busy}); end
        tick();
        vectors++; if (done !== 4'b0000) begin miscompares++; $display("FAIL rm_no_done got=%b exp=0000", done); end
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        exp_t e;
        rst = 1'b1; tick(); rst = 1'b0;
        set_slot(0, 28'h0008000, 10'd64); set_slot(1, 28'h0123400, 10'd8);
        set_slot(2, 28'h0200000, 10'd5);  set_slot(3, 28'h0070000, 10'd17);
        ddr_rdy = 1'b1; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            expect_grant(g % 4);
            for (int c = 0; c < 8 && gnt == 4'b0000; c++) tick();
            pop_exp(e);
            vectors++; if (gnt !== (4'b1 << e.idx)) begin miscompares++; $display("FAIL rr_gnt%0d got=%b exp=%b", g, gnt, 4'b1 << e.idx); end
            tick();
            if (e.idx != 2'd3) begin
                wr_burst_finish = 1'b1;
                tick();
                wr_burst_finish = 1'b0;
                vectors++; if ({gnt, rd_burst_req} !== {4'b1 << e.idx, 1'b1}) begin miscompares++; $display("FAIL rr_wrfin%0d got=%b exp=%b1", g, {gnt, rd_burst_req}, 4'b1 << e.idx); end
                rd_burst_finish = 1'b1;
            end else begin
                wr_burst_finish = 1'b1;
            end
            tick();
            rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
            vectors++; if (done !== (4'b1 << e.idx)) begin miscompares++; $display("FAIL rr_done%0d got=%b exp=%b", g, done, 4'b1 << e.idx); end
        end
        req = 4'b0000;
        tick(); tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_isa_read();
`ifndef ARB_ROUND_ROBIN_EN
        test_store_priority();
        test_rdy_gate();
`endif
        test_zero_len();
        test_reset_mid_store();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`endif
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
